// File: rtl/fsm_input_conditioner_if.sv
// Signal bundle between the raw button/VIO levels and the conditioner outputs.
// Optional FSM_INPUT_PULSE_CNT_EN adds the pulse_cnt probe.
`timescale 1ns/1ps
interface fsm_input_conditioner_if;
  // btn_x are free-running asynchronous levels (no handshake); inp_x are
  // single-cycle pulses with no back-pressure, and at most one is high per cycle.
  logic       btn_0;
  logic       btn_1;
  logic       inp_0;
  logic       inp_1;
  logic       busy;
`ifdef FSM_INPUT_PULSE_CNT_EN
  logic [7:0] pulse_cnt;

  modport master (output btn_0, btn_1, input inp_0, inp_1, busy, pulse_cnt);
  modport slave  (input btn_0, btn_1, output inp_0, inp_1, busy, pulse_cnt);
`else
  modport master (output btn_0, btn_1, input inp_0, inp_1, busy);
  modport slave  (input btn_0, btn_1, output inp_0, inp_1, busy);
`endif
endinterface

// File: rtl/fsm_input_conditioner.sv
// Two-channel synchronizer/debouncer/rise-pulse arbiter feeding top_seq.
// Optional FSM_INPUT_PULSE_CNT_EN adds an 8-bit wrapping pulse counter.
`timescale 1ns/1ps
module fsm_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int CNT_W           = 21
) (
  input  logic                    clk_125M,
  input  logic                    clear_n,
  fsm_input_conditioner_if.slave  io
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]            sync1_q, sync1_d;
  logic [1:0]            sync2_q, sync2_d;
  logic [1:0]            deb_q, deb_d;
  logic [1:0]            deb_prev_q, deb_prev_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]            pend_q, pend_d;
  logic [1:0]            inp_q, inp_d;
  logic                  busy_q, busy_d;
  logic [1:0]            rise;
  logic [1:0]            grant;

  always_comb begin
    sync1_d    = {io.btn_1, io.btn_0};
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    cnt_d      = cnt_q;

    // Any cycle where sync agrees with deb restarts the stability count.
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end

    rise     = deb_q & ~deb_prev_q;
    // Channel 0 has fixed priority; a deferred channel 1 request waits one cycle.
    grant[0] = pend_q[0];
    grant[1] = pend_q[1] & ~pend_q[0];
    pend_d   = (pend_q & ~grant) | rise;
    inp_d    = grant;
    busy_d   = (|cnt_q[0]) | (|cnt_q[1]) | (|pend_q);
  end

  always_ff @(posedge clk_125M or negedge clear_n) begin
    if (!clear_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      cnt_q      <= '0;
      pend_q     <= '0;
      inp_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      inp_q      <= inp_d;
      busy_q     <= busy_d;
    end
  end

  assign io.inp_0 = inp_q[0];
  assign io.inp_1 = inp_q[1];
  assign io.busy  = busy_q;

`ifdef FSM_INPUT_PULSE_CNT_EN
  logic [7:0] pulse_cnt_q, pulse_cnt_d;

  always_comb begin
    pulse_cnt_d = pulse_cnt_q + {7'd0, (inp_q[0] | inp_q[1])};
  end

  always_ff @(posedge clk_125M or negedge clear_n) begin
    if (!clear_n) begin
      pulse_cnt_q <= 8'd0;
    end else begin
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

  assign io.pulse_cnt = pulse_cnt_q;
`endif

endmodule
